// File: rtl/demux4_router.sv
// demux4_router: priority-decoded 1:4 valid/ready demux with one-beat register slice per channel
module demux4_router #(
  parameter int DW = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_sel,
  input  logic [DW-1:0] in_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data0,
  output logic [DW-1:0] out_data1,
  output logic [DW-1:0] out_data2,
  output logic [DW-1:0] out_data3,
  output logic [CW-1:0] drop_cnt
);
  logic [3:0]    valid_q, valid_d, dec, ld;
  logic [DW-1:0] data_q [4];
  logic [DW-1:0] data_d [4];
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          acc;
  always_comb begin
    dec = in_sel[0] ? 4'b0001 : in_sel[1] ? 4'b0010 : in_sel[2] ? 4'b0100 : in_sel[3] ? 4'b1000 : 4'b0000;
    in_ready = ~|dec | |(dec & (~valid_q | out_ready));
    acc = in_valid & in_ready;
    ld = dec & {4{acc}};
    // a load wins over a simultaneous drain, so a refilled channel stays full
    valid_d = ld | (valid_q & ~out_ready);
    for (int k = 0; k < 4; k++) data_d[k] = ld[k] ? in_data : data_q[k];
    drop_cnt_d = (acc && dec == 4'b0000 && drop_cnt_q != {CW{1'b1}}) ? drop_cnt_q + CW'(1) : drop_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 4'b0000;
      data_q     <= '{default: '0};
      drop_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_demux4_router.sv
// tb_demux4_router: directed vector table plus hand sequences for stall, pass-through and async reset
module tb_demux4_router;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_sel = 4'h0;
  logic [1:0] in_data = 2'd0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'h0;
  logic [1:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0] drop_cnt;
  int checks = 0;
  int failures = 0;

  demux4_router #(.DW(2), .CW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] sel;
    logic [1:0] d;
    logic [3:0] rdy;
    logic       er;
    logic [3:0] ev;
    logic [1:0] e0, e1, e2, e3;
    logic [1:0] edrop;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic beat(input logic v, input logic [3:0] sel, input logic [1:0] d,
                      input logic [3:0] rdy, input logic er, input logic [3:0] ev, input string n);
    @(negedge clk);
    in_valid = v; in_sel = sel; in_data = d; out_ready = rdy;
    #1 chk({n, ".in_ready"}, {7'd0, in_ready}, {7'd0, er});
    @(posedge clk);
    #1 chk({n, ".out_valid"}, {4'd0, out_valid}, {4'd0, ev});
  endtask

  task automatic chk_data(input string n, input logic [1:0] e0, input logic [1:0] e1,
                          input logic [1:0] e2, input logic [1:0] e3, input logic [1:0] ed);
    chk({n, ".data0"}, {6'd0, out_data0}, {6'd0, e0});
    chk({n, ".data1"}, {6'd0, out_data1}, {6'd0, e1});
    chk({n, ".data2"}, {6'd0, out_data2}, {6'd0, e2});
    chk({n, ".data3"}, {6'd0, out_data3}, {6'd0, e3});
    chk({n, ".drop"},  {6'd0, drop_cnt},  {6'd0, ed});
  endtask

  initial begin
    tv[0]  = '{1'b1, 4'h8, 2'd3, 4'hF, 1'b1, 4'b1000, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
    tv[1]  = '{1'b1, 4'h4, 2'd2, 4'hF, 1'b1, 4'b0100, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0};
    tv[2]  = '{1'b1, 4'h2, 2'd1, 4'hF, 1'b1, 4'b0010, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    tv[3]  = '{1'b1, 4'h1, 2'd0, 4'hF, 1'b1, 4'b0001, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    tv[4]  = '{1'b1, 4'hF, 2'd2, 4'hF, 1'b1, 4'b0001, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0};
    tv[5]  = '{1'b1, 4'hC, 2'd1, 4'hF, 1'b1, 4'b0100, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0};
    tv[6]  = '{1'b1, 4'hA, 2'd3, 4'hF, 1'b1, 4'b0010, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0};
    tv[7]  = '{1'b0, 4'h0, 2'd1, 4'hF, 1'b1, 4'b0000, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0};
    tv[8]  = '{1'b0, 4'h2, 2'd2, 4'h0, 1'b1, 4'b0000, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0};
    tv[9]  = '{1'b1, 4'h0, 2'd3, 4'hF, 1'b1, 4'b0000, 2'd2, 2'd3, 2'd1, 2'd3, 2'd1};
    tv[10] = '{1'b1, 4'h0, 2'd3, 4'hF, 1'b1, 4'b0000, 2'd2, 2'd3, 2'd1, 2'd3, 2'd2};
    tv[11] = '{1'b1, 4'h0, 2'd3, 4'hF, 1'b1, 4'b0000, 2'd2, 2'd3, 2'd1, 2'd3, 2'd3};
    tv[12] = '{1'b1, 4'h0, 2'd3, 4'hF, 1'b1, 4'b0000, 2'd2, 2'd3, 2'd1, 2'd3, 2'd3};
    tv[13] = '{1'b1, 4'h0, 2'd3, 4'hF, 1'b1, 4'b0000, 2'd2, 2'd3, 2'd1, 2'd3, 2'd3};

    #1;
    chk("reset.out_valid", {4'd0, out_valid}, 8'h00);
    chk("reset.in_ready", {7'd0, in_ready}, 8'h01);
    chk_data("reset", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      beat(tv[i].v, tv[i].sel, tv[i].d, tv[i].rdy, tv[i].er, tv[i].ev, $sformatf("vec%0d", i));
      chk_data($sformatf("vec%0d", i), tv[i].e0, tv[i].e1, tv[i].e2, tv[i].e3, tv[i].edrop);
    end

    for (int i = 0; i < 10; i++) begin
      beat(1'b1, 4'h1, 2'(i % 4), 4'hF, 1'b1, 4'b0001, $sformatf("pass%0d", i));
      chk($sformatf("pass%0d.data0", i), {6'd0, out_data0}, 8'(i % 4));
    end

    beat(1'b1, 4'h2, 2'd1, 4'b1101, 1'b1, 4'b0010, "bp0");
    chk_data("bp0", 2'd1, 2'd1, 2'd1, 2'd3, 2'd3);
    beat(1'b1, 4'h2, 2'd2, 4'b1101, 1'b0, 4'b0010, "bp1");
    chk("bp1.data1", {6'd0, out_data1}, 8'd1);
    beat(1'b1, 4'h2, 2'd2, 4'b1111, 1'b1, 4'b0010, "bp2");
    chk("bp2.data1", {6'd0, out_data1}, 8'd2);
    beat(1'b1, 4'h2, 2'd0, 4'b1101, 1'b0, 4'b0010, "bp3");
    chk("bp3.data1", {6'd0, out_data1}, 8'd2);
    beat(1'b1, 4'h2, 2'd0, 4'b1111, 1'b1, 4'b0010, "bp4");
    chk("bp4.data1", {6'd0, out_data1}, 8'd0);
    beat(1'b1, 4'h1, 2'd3, 4'b1111, 1'b1, 4'b0001, "bp5");
    chk_data("bp5", 2'd3, 2'd0, 2'd1, 2'd3, 2'd3);

    beat(1'b1, 4'h4, 2'd2, 4'b1011, 1'b1, 4'b0100, "pre_rst");
    chk_data("pre_rst", 2'd3, 2'd0, 2'd2, 2'd3, 2'd3);
    @(negedge clk);
    in_valid = 1'b0; in_sel = 4'h4;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {4'd0, out_valid}, 8'h00);
    chk("arst.in_ready", {7'd0, in_ready}, 8'h01);
    chk_data("arst", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    #1 rst_n = 1'b1;
    beat(1'b1, 4'h4, 2'd1, 4'hF, 1'b1, 4'b0100, "post_rst");
    chk_data("post_rst", 2'd0, 2'd0, 2'd1, 2'd0, 2'd0);
    beat(1'b0, 4'h4, 2'd3, 4'hF, 1'b1, 4'b0000, "post_rst_idle");
    chk("post_rst_idle.data2", {6'd0, out_data2}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
